run_dump_ctrl: RTL and testbench

RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

---
 rtl/pipe_sim_pkg.sv | 18 +
 rtl/dump_beat_reg.sv | 44 ++++
 rtl/run_dump_ctrl.sv | 120 ++++++++++++
 tb/tb_run_dump_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sim_pkg.sv
// Shared definitions for the run/dump controller: FSM state encoding and
// default parameter values used by the controller and its beat register.
package pipe_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_REGS  = 16;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_END_COUNT = 100;
  localparam int DEF_CNT_W     = 16;

endpackage : pipe_sim_pkg

// File: rtl/dump_beat_reg.sv
// Single-entry output register for the register dump stream: loads a new
// beat when empty or when the current beat is accepted, otherwise holds.
module dump_beat_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: the payload is reset as well as valid because the dump
      // outputs must read zero immediately on reset, not just be ignored.
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      idx_q   <= idx_i;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign data_o  = data_q;

endmodule : dump_beat_reg

// File: rtl/run_dump_ctrl.sv
// Runs a CPU for up to END_COUNT cycles (or until halt), then freezes it and
// streams its register file out as NUM_REGS valid/ready beats.
module run_dump_ctrl
  import pipe_sim_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int END_COUNT = DEF_END_COUNT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              halt_i,
  output logic              cpu_rst_o,
  output logic              cpu_en_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              timeout_o,
  output logic              done_o
);

  // One extra bit so the load index can reach NUM_REGS == 2**ADDR_W.
  localparam int               IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LD_END   = IDX_W'(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(END_COUNT - 1);

  state_e           state_q;
  logic             cpu_rst_q;
  logic             cpu_en_q;
  logic             timeout_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] ld_idx_q;

  logic in_dump;
  logic ld_exhausted;
  logic beat_accept;
  logic load_en;

  assign in_dump      = (state_q == ST_DUMP);
  assign ld_exhausted = (ld_idx_q == LD_END);
  assign beat_accept  = dump_valid_o && dump_ready_i;
  assign load_en      = in_dump && !ld_exhausted && (!dump_valid_o || dump_ready_i);
  assign rf_addr_o    = in_dump ? ld_idx_q[ADDR_W-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cpu_rst_q <= 1'b0;
      cpu_en_q  <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      ld_idx_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q   <= ST_RUN;
            cpu_rst_q <= 1'b1;
            cpu_en_q  <= 1'b1;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_i || (cnt_q == CNT_LAST)) begin
            // Halt takes priority, so a halt on the limit cycle is not a timeout.
            state_q   <= ST_DUMP;
            cpu_en_q  <= 1'b0;
            timeout_q <= !halt_i;
            ld_idx_q  <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DUMP: begin
          if (load_en) begin
            ld_idx_q <= ld_idx_q + IDX_W'(1);
          end
          if (ld_exhausted && beat_accept) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dump_beat_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_beat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_en),
    .ready_i (dump_ready_i),
    .idx_i   (ld_idx_q[ADDR_W-1:0]),
    .data_i  (rf_data_i),
    .valid_o (dump_valid_o),
    .idx_o   (dump_idx_o),
    .data_o  (dump_data_o)
  );

  assign cpu_rst_o   = cpu_rst_q;
  assign cpu_en_o    = cpu_en_q;
  assign cycle_cnt_o = cnt_q;
  assign timeout_o   = timeout_q;
  assign done_o      = done_q;

endmodule : run_dump_ctrl

// File: tb/tb_run_dump_ctrl.sv
// Directed bench for run_dump_ctrl: a default instance (16 regs, limit 100)
// and a 32-register instance; dump beats are checked against a scoreboard.
module tb_run_dump_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  logic clk;
  logic rst_a, rst_b;
  logic start, halt, ready;
  logic sel_b;

  logic          cpu_rst_a, cpu_en_a, valid_a, timeout_a, done_a;
  logic [AW-1:0] rf_addr_a, idx_a;
  logic [DW-1:0] rf_data_a, data_a;
  logic [CW-1:0] cnt_a;

  logic          cpu_rst_b, cpu_en_b, valid_b, timeout_b, done_b;
  logic [AW-1:0] rf_addr_b, idx_b;
  logic [DW-1:0] rf_data_b, data_b;
  logic [CW-1:0] cnt_b;

  // Register file model: address i holds 3*i+7.
  assign rf_data_a = DW'(3 * rf_addr_a + 7);
  assign rf_data_b = DW'(3 * rf_addr_b + 7);

  run_dump_ctrl u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst_a),
    .start_i      (start),
    .halt_i       (halt),
    .cpu_rst_o    (cpu_rst_a),
    .cpu_en_o     (cpu_en_a),
    .rf_addr_o    (rf_addr_a),
    .rf_data_i    (rf_data_a),
    .dump_valid_o (valid_a),
    .dump_ready_i (ready),
    .dump_idx_o   (idx_a),
    .dump_data_o  (data_a),
    .cycle_cnt_o  (cnt_a),
    .timeout_o    (timeout_a),
    .done_o       (done_a)
  );

  run_dump_ctrl #(
    .DATA_W    (DW),
    .NUM_REGS  (32),
    .ADDR_W    (AW),
    .END_COUNT (10),
    .CNT_W     (CW)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst_b),
    .start_i      (start),
    .halt_i       (halt),
    .cpu_rst_o    (cpu_rst_b),
    .cpu_en_o     (cpu_en_b),
    .rf_addr_o    (rf_addr_b),
    .rf_data_i    (rf_data_b),
    .dump_valid_o (valid_b),
    .dump_ready_i (ready),
    .dump_idx_o   (idx_b),
    .dump_data_o  (data_b),
    .cycle_cnt_o  (cnt_b),
    .timeout_o    (timeout_b),
    .done_o       (done_b)
  );

  // Observed outputs of whichever instance is under test.
  logic          m_cpu_rst, m_cpu_en, m_valid, m_timeout, m_done;
  logic [AW-1:0] m_rf_addr, m_idx;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cnt;

  assign m_cpu_rst = sel_b ? cpu_rst_b : cpu_rst_a;
  assign m_cpu_en  = sel_b ? cpu_en_b  : cpu_en_a;
  assign m_valid   = sel_b ? valid_b   : valid_a;
  assign m_timeout = sel_b ? timeout_b : timeout_a;
  assign m_done    = sel_b ? done_b    : done_a;
  assign m_rf_addr = sel_b ? rf_addr_b : rf_addr_a;
  assign m_idx     = sel_b ? idx_b     : idx_a;
  assign m_data    = sel_b ? data_b    : data_a;
  assign m_cnt     = sel_b ? cnt_b     : cnt_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.idx  = AW'(i);
      b.data = DW'(3 * i + 7);
      sb.push_back(b);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"}, m_cpu_rst, 0);
    check({tag, "_cpu_en"},  m_cpu_en, 0);
    check({tag, "_valid"},   m_valid, 0);
    check({tag, "_idx"},     m_idx, 0);
    check({tag, "_data"},    m_data, 0);
    check({tag, "_cnt"},     m_cnt, 0);
    check({tag, "_timeout"}, m_timeout, 0);
    check({tag, "_done"},    m_done, 0);
    check({tag, "_rf_addr"}, m_rf_addr, 0);
  endtask

  task automatic wait_dump(output int ncyc);
    ncyc = 0;
    while (m_cpu_en === 1'b1 && ncyc < 300) begin
      tick();
      ncyc++;
    end
    check("dump_entry_cpu_en", m_cpu_en, 0);
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_cnt !== CW'(target) && n < 300) begin
      tick();
      n++;
    end
    check("run_to_cnt", m_cnt, target);
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_entry_cnt", m_cnt, 0);
    check("run_entry_cpu_en", m_cpu_en, 1);
    check("run_entry_cpu_rst", m_cpu_rst, 1);
    check("run_entry_timeout", m_timeout, 0);
    check("run_entry_done", m_done, 0);
  endtask

  // Drains n beats; stall selects the ready pattern 1,0,0,1 instead of all-ones.
  task automatic drain(input int n, input bit stall, input int exp_cnt, input bit exp_to);
    int            got = 0;
    int            cyc = 0;
    bit            held = 1'b0;
    bit            rdy;
    logic [AW-1:0] h_idx = '0;
    logic [DW-1:0] h_data = '0;
    beat_t         e;
    tick();
    start = 1'b0;
    check("first_beat_valid", m_valid, 1);
    check("first_beat_idx", m_idx, 0);
    while (got < n && cyc < 200) begin
      rdy   = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      ready = rdy;
      if (held) begin
        check("hold_valid", m_valid, 1);
        check("hold_idx", m_idx, h_idx);
        check("hold_data", m_data, h_data);
      end
      if (m_valid) begin
        if (rdy) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("beat_idx", m_idx, e.idx);
            check("beat_data", m_data, e.data);
          end else begin
            check("beat_extra", m_valid, 0);
          end
          got++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_idx  = m_idx;
          h_data = m_data;
        end
      end else if (!stall) begin
        check("stream_gap", m_valid, 1);
      end
      tick();
      cyc++;
    end
    ready = 1'b0;
    check("beat_count", got, n);
    if (!stall) check("stream_cycles", cyc, n);
    check("done_set", m_done, 1);
    check("done_valid", m_valid, 0);
    check("sb_empty", sb.size(), 0);
    check("done_cpu_en", m_cpu_en, 0);
    check("done_cpu_rst", m_cpu_rst, 1);
    repeat (2) tick();
    check("done_hold_valid", m_valid, 0);
    check("done_hold_done", m_done, 1);
    check("done_hold_cnt", m_cnt, exp_cnt);
    check("done_hold_timeout", m_timeout, exp_to);
  endtask

  initial begin
    int ncyc;
    int n;
    rst_a = 1'b0;
    rst_b = 1'b0;
    sel_b = 1'b0;
    start = 1'b0;
    halt  = 1'b0;
    ready = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_a = 1'b1;
    repeat (3) tick();
    check("idle_cpu_en", m_cpu_en, 0);
    check("idle_cpu_rst", m_cpu_rst, 0);

    // Run to the cycle limit, then stream 16 beats with ready high.
    start_run();
    push_expected(16);
    wait_dump(ncyc);
    check("limit_run_len", ncyc, 100);
    check("limit_cnt", m_cnt, 99);
    check("limit_timeout", m_timeout, 1);
    check("limit_valid_at_entry", m_valid, 0);
    check("limit_rf_addr", m_rf_addr, 0);
    drain(16, 1'b0, 99, 1'b1);

    // Restart from DONE, pulse start mid-run, halt at cycle 40, stall the sink.
    start_run();
    push_expected(16);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_ignored_cnt", m_cnt, 5);
    check("run_start_ignored_en", m_cpu_en, 1);
    run_to(40);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt40_cpu_en", m_cpu_en, 0);
    check("halt40_cnt", m_cnt, 40);
    check("halt40_timeout", m_timeout, 0);
    start = 1'b1;
    drain(16, 1'b1, 40, 1'b0);

    // Halt on the same cycle as the limit: halt wins.
    start_run();
    push_expected(16);
    run_to(99);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_limit_cpu_en", m_cpu_en, 0);
    check("halt_limit_cnt", m_cnt, 99);
    check("halt_limit_timeout", m_timeout, 0);
    drain(16, 1'b0, 99, 1'b0);

    // Reset asserted while beat 5 is presented.
    start_run();
    halt = 1'b1;
    tick();
    halt  = 1'b0;
    ready = 1'b1;
    n = 0;
    while (!(m_valid === 1'b1 && m_idx === AW'(5)) && n < 50) begin
      tick();
      n++;
    end
    check("mid_dump_idx", m_idx, 5);
    check("mid_dump_data", m_data, 22);
    rst_a = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    ready = 1'b0;
    repeat (2) tick();
    rst_a = 1'b1;
    repeat (3) tick();
    check("post_reset_cpu_en", m_cpu_en, 0);
    check("post_reset_cpu_rst", m_cpu_rst, 0);
    check("post_reset_valid", m_valid, 0);
    start_run();
    push_expected(16);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("fresh_cnt", m_cnt, 0);
    check("fresh_timeout", m_timeout, 0);
    drain(16, 1'b0, 0, 1'b0);

    // 32-register instance with a 10-cycle limit.
    rst_a = 1'b0;
    sel_b = 1'b1;
    rst_b = 1'b1;
    repeat (2) tick();
    check("b_idle_cpu_en", m_cpu_en, 0);
    check("b_idle_valid", m_valid, 0);
    start_run();
    push_expected(32);
    wait_dump(ncyc);
    check("b_run_len", ncyc, 10);
    check("b_cnt", m_cnt, 9);
    check("b_timeout", m_timeout, 1);
    drain(32, 1'b0, 9, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_run_dump_ctrl
